// File: rtl/cerradura_secuencial.sv
// cerradura_secuencial: sequential 2-bit-digit code lock built around comparador.
// Optional lockout after repeated failures is enabled by defining CERRADURA_BLOQUEO_EN.
module comparador (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic       aeqb
);
   assign aeqb = (a == b);
endmodule

module cerradura_secuencial #(
   parameter int                      N_DIGITOS    = 4,
   parameter logic [2*N_DIGITOS-1:0]  CLAVE        = 8'b01_00_11_10,
   parameter int                      T_ABIERTO    = 8,
   parameter int                      MAX_INTENTOS = 3,
   parameter int                      T_BLOQUEO    = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] dig,
   input  logic       dig_valido,
   output logic       abierto,
   output logic       fallo,
   output logic       bloqueado,
   output logic [2:0] pos
);
   if (N_DIGITOS < 1 || N_DIGITOS > 8 || T_ABIERTO < 1 || MAX_INTENTOS < 1 || T_BLOQUEO < 1) begin : g_param_invalido
      $error("cerradura_secuencial: parameter out of range");
   end

   localparam logic [1:0] S_CAPTURA = 2'd0;
   localparam logic [1:0] S_ABIERTO = 2'd1;
`ifdef CERRADURA_BLOQUEO_EN
   localparam logic [1:0] S_BLOQUEO = 2'd2;
   localparam int T_MAX = (T_ABIERTO > T_BLOQUEO) ? T_ABIERTO : T_BLOQUEO;
   localparam int CW    = $clog2(MAX_INTENTOS + 1);
   logic [CW-1:0] r_fallos;
   logic          r_bloqueado;
`else
   localparam int T_MAX = T_ABIERTO;
`endif
   localparam int TW = $clog2(T_MAX + 1);

   logic [1:0]    r_estado;
   logic [2:0]    r_pos;
   logic          r_err;
   logic          r_abierto;
   logic          r_fallo;
   logic [TW-1:0] r_timer;
   logic [1:0]    w_dig_clave;
   logic          w_aeqb;
   logic          w_ultimo;
   logic          w_final;

   assign w_dig_clave = 2'(CLAVE >> {r_pos, 1'b0});
   assign w_ultimo    = (r_pos == 3'(N_DIGITOS - 1));
   // verdict only at the last digit, so the wrong position is never revealed
   assign w_final     = r_err | ~w_aeqb;

   comparador u_comparador (
      .a    (dig),
      .b    (w_dig_clave),
      .aeqb (w_aeqb)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_estado    <= S_CAPTURA;
         r_pos       <= 3'd0;
         r_err       <= 1'b0;
         r_abierto   <= 1'b0;
         r_fallo     <= 1'b0;
         r_timer     <= '0;
`ifdef CERRADURA_BLOQUEO_EN
         r_fallos    <= '0;
         r_bloqueado <= 1'b0;
`endif
      end else begin
         r_fallo <= 1'b0;
         case (r_estado)
            S_CAPTURA: begin
               if (dig_valido) begin
                  if (w_ultimo) begin
                     r_pos <= 3'd0;
                     r_err <= 1'b0;
                     if (w_final) begin
                        r_fallo <= 1'b1;
`ifdef CERRADURA_BLOQUEO_EN
                        if (r_fallos >= CW'(MAX_INTENTOS - 1)) begin
                           r_estado    <= S_BLOQUEO;
                           r_fallos    <= CW'(MAX_INTENTOS);
                           r_timer     <= TW'(T_BLOQUEO);
                           r_bloqueado <= 1'b1;
                        end else begin
                           r_fallos <= r_fallos + CW'(1);
                        end
`endif
                     end else begin
                        r_estado  <= S_ABIERTO;
                        r_abierto <= 1'b1;
                        r_timer   <= TW'(T_ABIERTO);
                     end
                  end else begin
                     r_pos <= r_pos + 3'd1;
                     r_err <= r_err | ~w_aeqb;
                  end
               end
            end
            S_ABIERTO: begin
               if (r_timer == TW'(1)) begin
                  r_estado  <= S_CAPTURA;
                  r_abierto <= 1'b0;
`ifdef CERRADURA_BLOQUEO_EN
                  r_fallos  <= '0;
`endif
               end else begin
                  r_timer <= r_timer - TW'(1);
               end
            end
`ifdef CERRADURA_BLOQUEO_EN
            S_BLOQUEO: begin
               if (r_timer == TW'(1)) begin
                  r_estado    <= S_CAPTURA;
                  r_bloqueado <= 1'b0;
                  r_fallos    <= '0;
               end else begin
                  r_timer <= r_timer - TW'(1);
               end
            end
`endif
            default: r_estado <= S_CAPTURA;
         endcase
      end
   end

   assign abierto = r_abierto;
   assign fallo   = r_fallo;
   assign pos     = r_pos;
`ifdef CERRADURA_BLOQUEO_EN
   assign bloqueado = r_bloqueado;
`else
   assign bloqueado = 1'b0;
`endif
endmodule

// File: tb/tb_cerradura_secuencial.sv
// tb_cerradura_secuencial: table vectors, directed corner sequences and random
// stimulus against a queue-based model of the lock; also an N_DIGITOS=1 instance.
module tb_cerradura_secuencial;
   localparam int         N     = 4;
   localparam int         T_AB  = 8;
   localparam int         T_BL  = 16;
   localparam int         MAXI  = 3;
   localparam logic [7:0] KEY   = 8'b01_00_11_10;
`ifdef CERRADURA_BLOQUEO_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] dig = 2'd0;
   logic       dig_valido = 1'b0;
   logic       abierto, fallo, bloqueado;
   logic [2:0] pos;
   logic [1:0] dig1 = 2'd0;
   logic       v1 = 1'b0;
   logic       abierto1, fallo1, bloqueado1;
   logic [2:0] pos1;

   int checks = 0;
   int failures = 0;

   cerradura_secuencial dut (
      .clk(clk), .rst(rst), .dig(dig), .dig_valido(dig_valido),
      .abierto(abierto), .fallo(fallo), .bloqueado(bloqueado), .pos(pos)
   );

   cerradura_secuencial #(.N_DIGITOS(1), .CLAVE(2'b11)) dut1 (
      .clk(clk), .rst(rst), .dig(dig1), .dig_valido(v1),
      .abierto(abierto1), .fallo(fallo1), .bloqueado(bloqueado1), .pos(pos1)
   );

   always #5 clk = ~clk;

   // Model: digits of the current attempt in a queue, plus remaining open/lock cycles.
   logic [1:0] entered[$];
   int  m_open = 0;
   int  m_lock = 0;
   int  m_fails = 0;
   bit  m_fallo = 1'b0;

   function automatic logic [1:0] kd(input int i);
      logic [7:0] k;
      k = KEY;
      return 2'(k >> (2 * i));
   endfunction

   task automatic model_reset();
      entered.delete();
      m_open = 0;
      m_lock = 0;
      m_fails = 0;
      m_fallo = 1'b0;
   endtask

   task automatic model_step(input logic v, input logic [1:0] d);
      bit ok;
      m_fallo = 1'b0;
      if (m_open > 0) begin
         m_open--;
         if (m_open == 0) m_fails = 0;
      end else if (m_lock > 0) begin
         m_lock--;
         if (m_lock == 0) m_fails = 0;
      end else if (v) begin
         entered.push_back(d);
         if (entered.size() == N) begin
            ok = 1'b1;
            for (int i = 0; i < N; i++) if (entered[i] != kd(i)) ok = 1'b0;
            entered.delete();
            if (ok) begin
               m_open = T_AB;
               m_fails = 0;
            end else begin
               m_fallo = 1'b1;
               if (LOCK_EN) begin
                  m_fails++;
                  if (m_fails >= MAXI) m_lock = T_BL;
               end
            end
         end
      end
   endtask

   task automatic check(input string nm);
      logic [5:0] exp_v, act_v;
      exp_v = {m_open > 0, m_fallo, m_lock > 0, 3'(entered.size())};
      act_v = {abierto, fallo, bloqueado, pos};
      checks++;
      if (act_v !== exp_v) begin
         failures++;
         $display("FAIL %s t=%0t {abierto,fallo,bloqueado,pos} got=%b expected=%b", nm, $time, act_v, exp_v);
      end
   endtask

   task automatic tick(input logic v, input logic [1:0] d, input string nm);
      dig_valido = v;
      dig = d;
      @(posedge clk);
      model_step(v, d);
      #1;
      dig_valido = 1'b0;
      check(nm);
   endtask

   task automatic idle(input int n, input string nm);
      for (int i = 0; i < n; i++) tick(1'b0, 2'd0, nm);
   endtask

   task automatic code(input logic [7:0] c, input string nm);
      for (int i = 0; i < N; i++) tick(1'b1, 2'(c >> (2 * i)), nm);
   endtask

   // Called at posedge+1: reset asserts mid-cycle, outputs must clear before the next edge.
   task automatic pulse_rst(input string nm);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check(nm);
      checks++;
      if ({abierto1, fallo1, bloqueado1, pos1} !== 6'd0) begin
         failures++;
         $display("FAIL %s_n1 got=%b expected=000000", nm, {abierto1, fallo1, bloqueado1, pos1});
      end
      #2 rst = 1'b0;
   endtask

   typedef struct packed {
      logic       v;
      logic [1:0] d;
      logic       ab;
      logic       fa;
      logic [2:0] p;
   } vec_t;

   vec_t tbl[23];

   initial begin
      tbl = '{
         '{1'b1, 2'd2, 1'b0, 1'b0, 3'd1}, '{1'b0, 2'd0, 1'b0, 1'b0, 3'd1}, '{1'b0, 2'd0, 1'b0, 1'b0, 3'd1},
         '{1'b1, 2'd3, 1'b0, 1'b0, 3'd2}, '{1'b0, 2'd0, 1'b0, 1'b0, 3'd2}, '{1'b0, 2'd0, 1'b0, 1'b0, 3'd2},
         '{1'b1, 2'd0, 1'b0, 1'b0, 3'd3}, '{1'b0, 2'd0, 1'b0, 1'b0, 3'd3}, '{1'b0, 2'd0, 1'b0, 1'b0, 3'd3},
         '{1'b1, 2'd1, 1'b1, 1'b0, 3'd0}, '{1'b0, 2'd0, 1'b1, 1'b0, 3'd0}, '{1'b0, 2'd0, 1'b1, 1'b0, 3'd0},
         '{1'b0, 2'd0, 1'b1, 1'b0, 3'd0}, '{1'b0, 2'd0, 1'b1, 1'b0, 3'd0}, '{1'b0, 2'd0, 1'b1, 1'b0, 3'd0},
         '{1'b0, 2'd0, 1'b1, 1'b0, 3'd0}, '{1'b0, 2'd0, 1'b1, 1'b0, 3'd0}, '{1'b0, 2'd0, 1'b0, 1'b0, 3'd0},
         '{1'b1, 2'd0, 1'b0, 1'b0, 3'd1}, '{1'b1, 2'd3, 1'b0, 1'b0, 3'd2}, '{1'b1, 2'd0, 1'b0, 1'b0, 3'd3},
         '{1'b1, 2'd1, 1'b0, 1'b1, 3'd0}, '{1'b0, 2'd0, 1'b0, 1'b0, 3'd0}
      };
      model_reset();
      #12;
      check("reset_state");
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("after_reset");

      for (int i = 0; i < 23; i++) begin
         tick(tbl[i].v, tbl[i].d, "tbl_model");
         checks++;
         if ({abierto, fallo, pos} !== {tbl[i].ab, tbl[i].fa, tbl[i].p}) begin
            failures++;
            $display("FAIL tbl[%0d] {abierto,fallo,pos} got=%b expected=%b", i,
                     {abierto, fallo, pos}, {tbl[i].ab, tbl[i].fa, tbl[i].p});
         end
      end
      code(KEY, "retry_after_fail");
      idle(T_AB + 1, "retry_window");

      code(KEY, "b2b_open");
      tick(1'b1, 2'd2, "strobe_in_open0");
      tick(1'b1, 2'd3, "strobe_in_open1");
      idle(T_AB, "open_window");
      code(KEY, "fresh_reopen");
      idle(T_AB + 1, "fresh_window");

      code(8'h00, "wrong1");
      code(8'h00, "wrong2");
      code(8'h00, "wrong3");
      code(KEY, "key_after_3_fails");
      checks++;
      if (abierto !== !LOCK_EN) begin
         failures++;
         $display("FAIL open_after_3_fails got=%b expected=%b", abierto, !LOCK_EN);
      end
      idle(T_BL + 2, "lock_window");
      code(KEY, "key_after_lock");
      idle(T_AB + 1, "after_lock_window");

      tick(1'b1, kd(0), "rst_mid0");
      tick(1'b1, kd(1), "rst_mid1");
      pulse_rst("rst_mid_entry");
      code(KEY, "open_after_rst");
      idle(2, "open_before_rst");
      pulse_rst("rst_in_open");
      code(KEY, "open_after_rst2");
      idle(T_AB + 1, "rst2_window");

      for (int i = 0; i < 600; i++) begin
         logic [1:0] d;
         d = ($urandom_range(0, 4) == 0) ? 2'($urandom) : kd(entered.size());
         tick(1'($urandom), d, "random");
      end
      idle(T_BL + T_AB + 2, "drain");

      // N_DIGITOS=1 instance: key 11 opens, everything else fails.
      for (int k = 3; k >= 0; k--) begin
         dig1 = 2'(k);
         v1 = 1'b1;
         @(posedge clk);
         #1;
         v1 = 1'b0;
         checks++;
         if ({abierto1, fallo1} !== {k == 3, k != 3}) begin
            failures++;
            $display("FAIL n1_digit%0d {abierto,fallo} got=%b expected=%b", k, {abierto1, fallo1}, {k == 3, k != 3});
         end
         repeat (T_AB + 1) @(posedge clk);
         #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
